// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the sram port arbiter: FSM states, owner ids and the
// round-robin pick used when both requesters contend in IDLE.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_INST = 1'b0,
        ARB_OWN_DATA = 1'b1
    } arb_owner_e;

    // A lone requester always wins; on contention the one that did not win last time goes.
    function automatic arb_owner_e rr_pick(input logic inst_req, input logic data_req,
                                           input arb_owner_e last_grant);
        arb_owner_e pick;
        if (inst_req && data_req) begin
            pick = (last_grant == ARB_OWN_INST) ? ARB_OWN_DATA : ARB_OWN_INST;
        end else if (data_req) begin
            pick = ARB_OWN_DATA;
        end else begin
            pick = ARB_OWN_INST;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access,
// one transaction in flight at a time, round-robin on contention.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            inst_req,
    input  logic            inst_wr,
    input  logic [DW/8-1:0] inst_wstrb,
    input  logic [AW-1:0]   inst_addr,
    input  logic [DW-1:0]   inst_wdata,
    output logic            inst_addr_ok,
    output logic            inst_data_ok,
    output logic [DW-1:0]   inst_rdata,

    input  logic            data_req,
    input  logic            data_wr,
    input  logic [DW/8-1:0] data_wstrb,
    input  logic [AW-1:0]   data_addr,
    input  logic [DW-1:0]   data_wdata,
    output logic            data_addr_ok,
    output logic            data_data_ok,
    output logic [DW-1:0]   data_rdata,

    output logic            mem_req,
    output logic            mem_wr,
    output logic [DW/8-1:0] mem_wstrb,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_addr_ok,
    input  logic            mem_data_ok,
    input  logic [DW-1:0]   mem_rdata,

    output logic            stallreq,
    output logic [1:0]      dbg_state
);

    // Handshakes: a requester holds req and its fields until *_addr_ok; the
    // transfer happens in the cycle where req and addr_ok are both high.
    // On the memory side mem_req is held until mem_addr_ok, and mem_data_ok
    // is only honoured once the address phase has completed.

    arb_state_e state;
    arb_owner_e last_grant;
    arb_owner_e owner;
    arb_owner_e pick;
    logic       inst_grant;
    logic       data_grant;

    always_comb begin
        pick       = rr_pick(inst_req, data_req, last_grant);
        inst_grant = 1'b0;
        data_grant = 1'b0;
        if (state == ARB_IDLE) begin
            inst_grant = inst_req && (pick == ARB_OWN_INST);
            data_grant = data_req && (pick == ARB_OWN_DATA);
        end
    end

    assign inst_addr_ok = inst_grant;
    assign data_addr_ok = data_grant;
    assign dbg_state    = state;

    assign stallreq = (inst_req && !inst_addr_ok) || (data_req && !data_addr_ok) ||
                      (state != ARB_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARB_IDLE;
            last_grant   <= ARB_OWN_INST;
            owner        <= ARB_OWN_INST;
            mem_req      <= 1'b0;
            mem_wr       <= 1'b0;
            mem_wstrb    <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            inst_data_ok <= 1'b0;
            data_data_ok <= 1'b0;
            inst_rdata   <= '0;
            data_rdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (inst_grant) begin
                        state      <= ARB_ADDR;
                        owner      <= ARB_OWN_INST;
                        last_grant <= ARB_OWN_INST;
                        mem_req    <= 1'b1;
                        mem_wr     <= inst_wr;
                        mem_wstrb  <= inst_wr ? inst_wstrb : '0;
                        mem_addr   <= inst_addr;
                        mem_wdata  <= inst_wdata;
                    end else if (data_grant) begin
                        state      <= ARB_ADDR;
                        owner      <= ARB_OWN_DATA;
                        last_grant <= ARB_OWN_DATA;
                        mem_req    <= 1'b1;
                        mem_wr     <= data_wr;
                        mem_wstrb  <= data_wr ? data_wstrb : '0;
                        mem_addr   <= data_addr;
                        mem_wdata  <= data_wdata;
                    end
                end
                ARB_ADDR: begin
                    if (mem_addr_ok) begin
                        state   <= ARB_DATA;
                        mem_req <= 1'b0;
                    end
                end
                ARB_DATA: begin
                    if (mem_data_ok) begin
                        state <= ARB_RESP;
                        // Writes return zero so the requester never sees stale bus data.
                        if (owner == ARB_OWN_INST) begin
                            inst_data_ok <= 1'b1;
                            inst_rdata   <= mem_wr ? '0 : mem_rdata;
                        end else begin
                            data_data_ok <= 1'b1;
                            data_rdata   <= mem_wr ? '0 : mem_rdata;
                        end
                    end
                end
                ARB_RESP: begin
                    state        <= ARB_IDLE;
                    inst_data_ok <= 1'b0;
                    data_data_ok <= 1'b0;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-cycle vector tables for the basic
// read and contention flows, hand-written sequences for the multi-cycle corners.
module tb_sram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [AW-1:0] INST_A = 32'hBFC0_0000;
    localparam logic [AW-1:0] DATA_A = 32'h8000_1000;

    logic            clk;
    logic            rst;
    logic            inst_req, inst_wr;
    logic [DW/8-1:0] inst_wstrb;
    logic [AW-1:0]   inst_addr;
    logic [DW-1:0]   inst_wdata;
    logic            inst_addr_ok, inst_data_ok;
    logic [DW-1:0]   inst_rdata;
    logic            data_req, data_wr;
    logic [DW/8-1:0] data_wstrb;
    logic [AW-1:0]   data_addr;
    logic [DW-1:0]   data_wdata;
    logic            data_addr_ok, data_data_ok;
    logic [DW-1:0]   data_rdata;
    logic            mem_req, mem_wr;
    logic [DW/8-1:0] mem_wstrb;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_addr_ok, mem_data_ok;
    logic [DW-1:0]   mem_rdata;
    logic            stallreq;
    logic [1:0]      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .stallreq(stallreq), .dbg_state(dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst;
        logic        inst_req;
        logic        data_req;
        logic        mem_addr_ok;
        logic        mem_data_ok;
        logic [31:0] mem_rdata;
        logic        exp_inst_aok;
        logic        exp_data_aok;
        logic        exp_mem_req;
        logic        exp_inst_dok;
        logic        exp_data_dok;
        logic        exp_stall;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic r, input logic ir, input logic dr,
                                input logic aok, input logic dok, input logic [31:0] rd,
                                input logic e_iaok, input logic e_daok, input logic e_mreq,
                                input logic e_idok, input logic e_ddok, input logic e_stall,
                                input logic [31:0] e_addr, input logic [31:0] e_rdata);
        vec_t v;
        v.rst = r; v.inst_req = ir; v.data_req = dr;
        v.mem_addr_ok = aok; v.mem_data_ok = dok; v.mem_rdata = rd;
        v.exp_inst_aok = e_iaok; v.exp_data_aok = e_daok; v.exp_mem_req = e_mreq;
        v.exp_inst_dok = e_idok; v.exp_data_dok = e_ddok; v.exp_stall = e_stall;
        v.exp_addr = e_addr; v.exp_rdata = e_rdata;
        return v;
    endfunction

    // Scoreboard-style compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h @%0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_wstrb = '0; inst_addr = INST_A; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = DATA_A; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_mem(input logic aok, input logic dok, input logic [31:0] rd);
        mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("reset_state", {30'd0, dbg_state}, 32'd0);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("reset_inst_dok", {31'd0, inst_data_ok}, 32'd0);
        check("reset_data_rdata", data_rdata, 32'd0);
        check("reset_stall", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single inst read, then contention from reset with both requesters held high.
        vecs[0]  = mk(0,1,0, 0,0,32'h0,          1,0,0,0,0,0, INST_A, 0);
        vecs[1]  = mk(0,0,0, 1,0,32'h0,          0,0,1,0,0,1, INST_A, 0);
        vecs[2]  = mk(0,0,0, 0,1,32'h3C08_0001,  0,0,0,0,0,1, INST_A, 0);
        vecs[3]  = mk(0,0,0, 0,0,32'h0,          0,0,0,1,0,1, INST_A, 32'h3C08_0001);
        vecs[4]  = mk(0,0,0, 0,0,32'h0,          0,0,0,0,0,0, INST_A, 0);
        vecs[5]  = mk(1,1,1, 1,1,32'hFFFF_FFFF,  0,1,0,0,0,1, DATA_A, 0);
        vecs[6]  = mk(0,1,1, 1,1,32'hFFFF_FFFF,  0,0,1,0,0,1, DATA_A, 0);
        vecs[7]  = mk(0,1,1, 1,1,32'h1111_2222,  0,0,0,0,0,1, DATA_A, 0);
        vecs[8]  = mk(0,1,1, 1,1,32'hFFFF_FFFF,  0,0,0,0,1,1, DATA_A, 32'h1111_2222);
        vecs[9]  = mk(0,1,1, 1,1,32'hFFFF_FFFF,  1,0,0,0,0,1, INST_A, 0);
        vecs[10] = mk(0,1,1, 1,1,32'hFFFF_FFFF,  0,0,1,0,0,1, INST_A, 0);
        vecs[11] = mk(0,1,1, 1,1,32'h3333_4444,  0,0,0,0,0,1, INST_A, 0);
        vecs[12] = mk(0,1,1, 1,1,32'hFFFF_FFFF,  0,0,0,1,0,1, INST_A, 32'h3333_4444);
        vecs[13] = mk(0,1,1, 1,1,32'hFFFF_FFFF,  0,1,0,0,0,1, DATA_A, 0);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            inst_req = vecs[i].inst_req;
            data_req = vecs[i].data_req;
            set_mem(vecs[i].mem_addr_ok, vecs[i].mem_data_ok, vecs[i].mem_rdata);
            #1;
            check($sformatf("v%0d_inst_addr_ok", i), {31'd0, inst_addr_ok}, {31'd0, vecs[i].exp_inst_aok});
            check($sformatf("v%0d_data_addr_ok", i), {31'd0, data_addr_ok}, {31'd0, vecs[i].exp_data_aok});
            check($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].exp_mem_req});
            check($sformatf("v%0d_inst_data_ok", i), {31'd0, inst_data_ok}, {31'd0, vecs[i].exp_inst_dok});
            check($sformatf("v%0d_data_data_ok", i), {31'd0, data_data_ok}, {31'd0, vecs[i].exp_data_dok});
            check($sformatf("v%0d_stallreq", i), {31'd0, stallreq}, {31'd0, vecs[i].exp_stall});
            if (vecs[i].exp_mem_req) check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
            if (vecs[i].exp_inst_dok) check($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].exp_rdata);
            if (vecs[i].exp_data_dok) check($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].exp_rdata);
        end

        // Data write: exact fields reach the port, response carries zero rdata.
        do_reset();
        @(negedge clk);
        data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
        #1 check("wr_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk);
        data_req = 0; data_wr = 0; data_wstrb = '0; data_wdata = '0;
        set_mem(1, 0, 32'h0);
        #1;
        check("wr_mem_req", {31'd0, mem_req}, 32'd1);
        check("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
        check("wr_mem_wstrb", {28'd0, mem_wstrb}, 32'h3);
        check("wr_mem_addr", mem_addr, DATA_A);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        set_mem(0, 1, 32'h1234_5678);
        @(negedge clk);
        set_mem(0, 0, 32'h0);
        #1;
        check("wr_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        check("wr_data_rdata", data_rdata, 32'd0);

        // Read with all strobes set, memory stalls the address phase for 5 cycles.
        @(negedge clk);
        inst_req = 1; inst_wr = 0; inst_wstrb = 4'hF; inst_addr = 32'h0000_0040;
        #1 check("ws_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        @(negedge clk);
        inst_req = 0; inst_wstrb = '0; inst_addr = INST_A;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("ws_mem_req_c%0d", c), {31'd0, mem_req}, 32'd1);
            check($sformatf("ws_stall_c%0d", c), {31'd0, stallreq}, 32'd1);
            check($sformatf("ws_mem_wstrb_c%0d", c), {28'd0, mem_wstrb}, 32'd0);
            @(negedge clk);
        end
        set_mem(1, 0, 32'h0);
        #1 check("ws_mem_req_accept", {31'd0, mem_req}, 32'd1);
        @(negedge clk);
        set_mem(0, 1, 32'hCAFE_F00D);
        #1 check("ws_mem_req_dropped", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        set_mem(0, 0, 32'h0);
        #1;
        check("ws_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        check("ws_inst_rdata", inst_rdata, 32'hCAFE_F00D);
        @(negedge clk);
        #1 check("ws_data_ok_one_cycle", {31'd0, inst_data_ok}, 32'd0);

        // Reset during ADDR drops mem_req before any clock edge.
        @(negedge clk);
        data_req = 1;
        @(negedge clk);
        data_req = 0;
        #1 check("ra_mem_req_before", {31'd0, mem_req}, 32'd1);
        #1 rst = 1'b1;
        #1 check("ra_mem_req_async", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while in DATA, then a stale mem_data_ok must be ignored.
        @(negedge clk);
        data_req = 1;
        @(negedge clk);
        data_req = 0;
        set_mem(1, 0, 32'h0);
        @(negedge clk);
        set_mem(0, 0, 32'h0);
        #1 check("rd_in_data_state", {30'd0, dbg_state}, 32'd2);
        rst = 1'b1;
        #1;
        check("rd_state_idle", {30'd0, dbg_state}, 32'd0);
        check("rd_mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        set_mem(0, 1, 32'h5555_AAAA);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("rd_no_data_ok_c%0d", c),
                  {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            check($sformatf("rd_idle_c%0d", c), {30'd0, dbg_state}, 32'd0);
        end
        set_mem(0, 0, 32'h0);

        // Inst raises and drops req while a data transaction is in flight.
        do_reset();
        @(negedge clk);
        data_req = 1;
        #1 check("dr_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        @(negedge clk);
        data_req = 0; inst_req = 1;
        set_mem(1, 0, 32'h0);
        #1;
        check("dr_inst_no_aok", {31'd0, inst_addr_ok}, 32'd0);
        check("dr_stall", {31'd0, stallreq}, 32'd1);
        @(negedge clk);
        inst_req = 0;
        set_mem(0, 1, 32'h7777_8888);
        @(negedge clk);
        set_mem(0, 0, 32'h0);
        #1 check("dr_data_rdata", data_rdata, 32'h7777_8888);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("dr_no_inst_aok_c%0d", c), {31'd0, inst_addr_ok}, 32'd0);
            check($sformatf("dr_no_mem_req_c%0d", c), {31'd0, mem_req}, 32'd0);
            check($sformatf("dr_no_stall_c%0d", c), {31'd0, stallreq}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
